// File: rtl/ex_mem_pipe_reg_pkg.sv
// Shared definitions for the EX/MEM pipeline register: default widths,
// load-mode encodings and the packed MEM/WB control bundle.
package ex_mem_pipe_reg_pkg;

  localparam int DATA_W_DEF      = 32;
  localparam int REG_ADDR_W_DEF  = 5;
  localparam int LOAD_MODE_W_DEF = 2;
  localparam int CNT_W_DEF       = 16;

  // Register $zero never receives a write, so it is never a forwarding source.
  localparam int REG_ZERO = 0;

  typedef enum logic [1:0] {
    LM_WORD = 2'd0,
    LM_HALF = 2'd1,
    LM_BYTE = 2'd2
  } load_mode_e;

  typedef struct packed {
    logic reg_write;
    logic mem_write;
    logic mem_read;
    logic mem_to_reg;
    logic branch;
    logic zero;
  } ctrl_t;

  // A non-valid slot must never write the register file or memory.
  function automatic ctrl_t gate_side_effects(ctrl_t c, logic valid);
    ctrl_t r;
    r           = c;
    r.reg_write = c.reg_write & valid;
    r.mem_write = c.mem_write & valid;
    return r;
  endfunction

endpackage

// File: rtl/ex_mem_pipe_reg_if.sv
// EX -> MEM stage bundle: hazard controls, EX-side inputs, MEM-side outputs,
// derived branch/forward flags and the hazard event counters.
interface ex_mem_pipe_reg_if #(
  parameter int DATA_W      = 32,
  parameter int REG_ADDR_W  = 5,
  parameter int LOAD_MODE_W = 2,
  parameter int CNT_W       = 16
) ();

  logic                   stall;
  logic                   flush;

  logic                   valid_in;
  logic                   RegWrite_in;
  logic                   MemWrite_in;
  logic                   MemRead_in;
  logic                   MemToReg_in;
  logic                   branch_in;
  logic                   zero_in;
  logic [LOAD_MODE_W-1:0] load_mode_in;
  logic [REG_ADDR_W-1:0]  writebackDestination_in;
  logic [DATA_W-1:0]      aluResult_in;
  logic [DATA_W-1:0]      rt_in;
  logic [DATA_W-1:0]      pc_in;

  logic                   valid_out;
  logic                   RegWrite_out;
  logic                   MemWrite_out;
  logic                   MemRead_out;
  logic                   MemToReg_out;
  logic                   branch_out;
  logic                   zero_out;
  logic [LOAD_MODE_W-1:0] load_mode_out;
  logic [REG_ADDR_W-1:0]  writebackDestination_out;
  logic [DATA_W-1:0]      aluResult_out;
  logic [DATA_W-1:0]      rt_out;
  logic [DATA_W-1:0]      pc_out;

  logic                   branch_taken;
  logic                   fwd_en;
  logic [CNT_W-1:0]       stall_cnt;
  logic [CNT_W-1:0]       flush_cnt;

  modport master (
    output stall, flush, valid_in, RegWrite_in, MemWrite_in, MemRead_in,
           MemToReg_in, branch_in, zero_in, load_mode_in,
           writebackDestination_in, aluResult_in, rt_in, pc_in,
    input  valid_out, RegWrite_out, MemWrite_out, MemRead_out, MemToReg_out,
           branch_out, zero_out, load_mode_out, writebackDestination_out,
           aluResult_out, rt_out, pc_out, branch_taken, fwd_en,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  stall, flush, valid_in, RegWrite_in, MemWrite_in, MemRead_in,
           MemToReg_in, branch_in, zero_in, load_mode_in,
           writebackDestination_in, aluResult_in, rt_in, pc_in,
    output valid_out, RegWrite_out, MemWrite_out, MemRead_out, MemToReg_out,
           branch_out, zero_out, load_mode_out, writebackDestination_out,
           aluResult_out, rt_out, pc_out, branch_taken, fwd_en,
           stall_cnt, flush_cnt
  );

endinterface

// File: rtl/ex_mem_pipe_reg_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc_i,
  output logic [W-1:0] count_o
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc_i && (count_q != {W{1'b1}})) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count_o = count_q;

endmodule

// File: rtl/ex_mem_pipe_reg.sv
// EX/MEM pipeline register with valid tracking, stall/flush handling,
// branch-resolution and forwarding flags, and saturating hazard counters.
module ex_mem_pipe_reg
  import ex_mem_pipe_reg_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int REG_ADDR_W  = REG_ADDR_W_DEF,
  parameter int LOAD_MODE_W = LOAD_MODE_W_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  ex_mem_pipe_reg_if.slave    bus
);

  logic                   valid_q, valid_d;
  ctrl_t                  ctrl_q, ctrl_d;
  ctrl_t                  ctrl_in;
  logic [LOAD_MODE_W-1:0] lm_q, lm_d;
  logic [REG_ADDR_W-1:0]  dest_q, dest_d;
  logic [DATA_W-1:0]      alu_q, alu_d;
  logic [DATA_W-1:0]      rt_q, rt_d;
  logic [DATA_W-1:0]      pc_q, pc_d;

  assign ctrl_in = '{
    reg_write:  bus.RegWrite_in,
    mem_write:  bus.MemWrite_in,
    mem_read:   bus.MemRead_in,
    mem_to_reg: bus.MemToReg_in,
    branch:     bus.branch_in,
    zero:       bus.zero_in
  };

  // Flush outranks stall; datapath fields still load on a flush so the
  // bubble carries deterministic (if meaningless) contents.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    lm_d    = lm_q;
    dest_d  = dest_q;
    alu_d   = alu_q;
    rt_d    = rt_q;
    pc_d    = pc_q;
    if (bus.flush || !bus.stall) begin
      lm_d   = bus.load_mode_in;
      dest_d = bus.writebackDestination_in;
      alu_d  = bus.aluResult_in;
      rt_d   = bus.rt_in;
      pc_d   = bus.pc_in;
      if (bus.flush) begin
        valid_d = 1'b0;
        ctrl_d  = '0;
      end else begin
        valid_d = bus.valid_in;
        ctrl_d  = gate_side_effects(ctrl_in, bus.valid_in);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      lm_q    <= '0;
      dest_q  <= '0;
      alu_q   <= '0;
      rt_q    <= '0;
      pc_q    <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      lm_q    <= lm_d;
      dest_q  <= dest_d;
      alu_q   <= alu_d;
      rt_q    <= rt_d;
      pc_q    <= pc_d;
    end
  end

  assign bus.valid_out                = valid_q;
  assign bus.RegWrite_out             = ctrl_q.reg_write;
  assign bus.MemWrite_out             = ctrl_q.mem_write;
  assign bus.MemRead_out              = ctrl_q.mem_read;
  assign bus.MemToReg_out             = ctrl_q.mem_to_reg;
  assign bus.branch_out               = ctrl_q.branch;
  assign bus.zero_out                 = ctrl_q.zero;
  assign bus.load_mode_out            = lm_q;
  assign bus.writebackDestination_out = dest_q;
  assign bus.aluResult_out            = alu_q;
  assign bus.rt_out                   = rt_q;
  assign bus.pc_out                   = pc_q;

  // Derived purely from registered state: no EX-to-MEM combinational path.
  assign bus.branch_taken = valid_q & ctrl_q.branch & ctrl_q.zero;
  assign bus.fwd_en       = valid_q & ctrl_q.reg_write &
                            (dest_q != REG_ADDR_W'(REG_ZERO));

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (bus.stall & ~bus.flush),
    .count_o (bus.stall_cnt)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk     (clk),
    .rst     (rst),
    .inc_i   (bus.flush),
    .count_o (bus.flush_cnt)
  );

endmodule

// File: tb/tb_ex_mem_pipe_reg.sv
// Scoreboard bench for ex_mem_pipe_reg: directed hazard scenarios followed by
// randomized traffic, each cycle checked against a behavioural model.
module tb_ex_mem_pipe_reg;
  import ex_mem_pipe_reg_pkg::*;

  localparam int CNT_W   = 3;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ex_mem_pipe_reg_if #(.CNT_W(CNT_W)) bus ();

  ex_mem_pipe_reg #(.CNT_W(CNT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst, stall, flush, valid;
    logic        rw, mw, mr, m2r, br, zr;
    logic [1:0]  lm;
    logic [4:0]  dest;
    logic [31:0] alu, rt, pc;
  } stim_t;

  // MEM-stage contents as seen by the consumer, plus the two event tallies.
  typedef struct {
    logic        valid;
    logic        rw, mw, mr, m2r, br, zr;
    logic [1:0]  lm;
    logic [4:0]  dest;
    logic [31:0] alu, rt, pc;
    int          scnt, fcnt;
  } exp_t;

  exp_t m;
  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   txn        = 0;

  task automatic cmp(input string nm, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  function automatic stim_t idle();
    stim_t s;
    s = '{rst: 1'b0, stall: 1'b0, flush: 1'b0, valid: 1'b0, rw: 1'b0, mw: 1'b0,
          mr: 1'b0, m2r: 1'b0, br: 1'b0, zr: 1'b0, lm: 2'd0, dest: 5'd0,
          alu: 32'd0, rt: 32'd0, pc: 32'd0};
    return s;
  endfunction

  function automatic stim_t rand_stim();
    stim_t s;
    s.rst   = ($urandom_range(0, 39) == 0);
    s.stall = ($urandom_range(0, 3) == 0);
    s.flush = ($urandom_range(0, 7) == 0);
    s.valid = ($urandom_range(0, 3) != 0);
    s.rw    = 1'($urandom_range(0, 1));
    s.mw    = 1'($urandom_range(0, 1));
    s.mr    = 1'($urandom_range(0, 1));
    s.m2r   = 1'($urandom_range(0, 1));
    s.br    = 1'($urandom_range(0, 1));
    s.zr    = 1'($urandom_range(0, 1));
    s.lm    = 2'($urandom_range(0, 2));
    s.dest  = ($urandom_range(0, 3) == 0) ? 5'd0 : 5'($urandom_range(1, 31));
    s.alu   = $urandom;
    s.rt    = $urandom;
    s.pc    = $urandom & 32'hFFFF_FFFC;
    return s;
  endfunction

  // Reference behaviour: reset clears, flush inserts a bubble, stall freezes
  // the slot, otherwise the slot takes the EX instruction (no writes if invalid).
  task automatic model_step(input stim_t s);
    if (s.rst) begin
      m.valid = 0; m.rw = 0; m.mw = 0; m.mr = 0; m.m2r = 0; m.br = 0; m.zr = 0;
      m.lm = 0; m.dest = 0; m.alu = 0; m.rt = 0; m.pc = 0; m.scnt = 0; m.fcnt = 0;
    end else if (s.flush) begin
      m.valid = 0; m.rw = 0; m.mw = 0; m.mr = 0; m.m2r = 0; m.br = 0; m.zr = 0;
      m.lm = s.lm; m.dest = s.dest; m.alu = s.alu; m.rt = s.rt; m.pc = s.pc;
      m.fcnt = (m.fcnt < CNT_MAX) ? m.fcnt + 1 : CNT_MAX;
    end else if (s.stall) begin
      m.scnt = (m.scnt < CNT_MAX) ? m.scnt + 1 : CNT_MAX;
    end else begin
      m.valid = s.valid;
      m.rw = s.rw && s.valid;
      m.mw = s.mw && s.valid;
      m.mr = s.mr; m.m2r = s.m2r; m.br = s.br; m.zr = s.zr;
      m.lm = s.lm; m.dest = s.dest; m.alu = s.alu; m.rt = s.rt; m.pc = s.pc;
    end
  endtask

  // Called at posedge+1; returns at the following posedge+1.
  task automatic step(input stim_t s);
    rst                         = s.rst;
    bus.stall                   = s.stall;
    bus.flush                   = s.flush;
    bus.valid_in                = s.valid;
    bus.RegWrite_in             = s.rw;
    bus.MemWrite_in             = s.mw;
    bus.MemRead_in              = s.mr;
    bus.MemToReg_in             = s.m2r;
    bus.branch_in               = s.br;
    bus.zero_in                 = s.zr;
    bus.load_mode_in            = s.lm;
    bus.writebackDestination_in = s.dest;
    bus.aluResult_in            = s.alu;
    bus.rt_in                   = s.rt;
    bus.pc_in                   = s.pc;
    model_step(s);
    @(posedge clk);
    sb.push_back(m);
    #1;
  endtask

  // Monitor: every registered result is compared half a cycle after its edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        txn++;
        cmp("valid_out", 32'(bus.valid_out), 32'(e.valid));
        cmp("RegWrite_out", 32'(bus.RegWrite_out), 32'(e.rw));
        cmp("MemWrite_out", 32'(bus.MemWrite_out), 32'(e.mw));
        cmp("MemRead_out", 32'(bus.MemRead_out), 32'(e.mr));
        cmp("MemToReg_out", 32'(bus.MemToReg_out), 32'(e.m2r));
        cmp("branch_out", 32'(bus.branch_out), 32'(e.br));
        cmp("zero_out", 32'(bus.zero_out), 32'(e.zr));
        cmp("load_mode_out", 32'(bus.load_mode_out), 32'(e.lm));
        cmp("dest_out", 32'(bus.writebackDestination_out), 32'(e.dest));
        cmp("aluResult_out", bus.aluResult_out, e.alu);
        cmp("rt_out", bus.rt_out, e.rt);
        cmp("pc_out", bus.pc_out, e.pc);
        cmp("branch_taken", 32'(bus.branch_taken), 32'(e.valid & e.br & e.zr));
        cmp("fwd_en", 32'(bus.fwd_en), 32'(e.valid & e.rw & (e.dest != 5'd0)));
        cmp("stall_cnt", 32'(bus.stall_cnt), 32'(e.scnt));
        cmp("flush_cnt", 32'(bus.flush_cnt), 32'(e.fcnt));
        $display("txn %0d v=%0b rw=%0b mw=%0b dest=%0d alu=%h bt=%0b fwd=%0b scnt=%0d fcnt=%0d",
                 txn, bus.valid_out, bus.RegWrite_out, bus.MemWrite_out,
                 bus.writebackDestination_out, bus.aluResult_out,
                 bus.branch_taken, bus.fwd_en, bus.stall_cnt, bus.flush_cnt);
      end
    end
  end

  initial begin
    stim_t s;
    m = '{valid: 1'b0, rw: 1'b0, mw: 1'b0, mr: 1'b0, m2r: 1'b0, br: 1'b0, zr: 1'b0,
          lm: 2'd0, dest: 5'd0, alu: 32'd0, rt: 32'd0, pc: 32'd0, scnt: 0, fcnt: 0};
    s = idle();
    s.rst = 1'b1;
    @(posedge clk);
    #1;

    // Reset with every input driven high.
    s = '{rst: 1'b1, stall: 1'b1, flush: 1'b1, valid: 1'b1, rw: 1'b1, mw: 1'b1,
          mr: 1'b1, m2r: 1'b1, br: 1'b1, zr: 1'b1, lm: 2'b11, dest: 5'h1F,
          alu: 32'hFFFF_FFFF, rt: 32'hFFFF_FFFF, pc: 32'hFFFF_FFFF};
    step(s);
    cmp("reset_valid", 32'(bus.valid_out), 32'd0);
    cmp("reset_alu", bus.aluResult_out, 32'd0);
    cmp("reset_stall_cnt", 32'(bus.stall_cnt), 32'd0);

    // Load with a forwardable destination, then with $zero.
    s = idle(); s.valid = 1; s.rw = 1; s.dest = 5'd9; s.alu = 32'h1234_5678;
    step(s);
    cmp("load_alu", bus.aluResult_out, 32'h1234_5678);
    cmp("load_fwd_en", 32'(bus.fwd_en), 32'd1);
    s.dest = 5'd0;
    step(s);
    cmp("dest0_fwd_en", 32'(bus.fwd_en), 32'd0);

    // Hold for three stalled cycles, then release.
    s = idle(); s.valid = 1; s.alu = 32'h10;
    step(s);
    s.alu = 32'h20; s.stall = 1;
    for (int i = 0; i < 3; i++) step(s);
    cmp("stall_hold_alu", bus.aluResult_out, 32'h10);
    cmp("stall_cnt_3", 32'(bus.stall_cnt), 32'd3);
    s.stall = 0;
    step(s);
    cmp("release_alu", bus.aluResult_out, 32'h20);

    // Flush beats stall.
    s = idle(); s.stall = 1; s.flush = 1; s.valid = 1; s.mw = 1;
    step(s);
    cmp("flush_valid", 32'(bus.valid_out), 32'd0);
    cmp("flush_memwrite", 32'(bus.MemWrite_out), 32'd0);
    cmp("flush_cnt_1", 32'(bus.flush_cnt), 32'd1);
    cmp("flush_stall_cnt", 32'(bus.stall_cnt), 32'd3);

    // Branch resolution and bubble gating.
    s = idle(); s.valid = 1; s.br = 1; s.zr = 1;
    step(s);
    cmp("branch_taken_v1", 32'(bus.branch_taken), 32'd1);
    s.valid = 0; s.rw = 1; s.mw = 1; s.dest = 5'd3;
    step(s);
    cmp("branch_taken_v0", 32'(bus.branch_taken), 32'd0);
    cmp("bubble_regwrite", 32'(bus.RegWrite_out), 32'd0);
    cmp("bubble_memwrite", 32'(bus.MemWrite_out), 32'd0);

    // Counter saturation.
    s = idle(); s.stall = 1;
    for (int i = 0; i < 10; i++) step(s);
    cmp("stall_cnt_sat", 32'(bus.stall_cnt), 32'(CNT_MAX));

    // Reset while stalling and flushing, then normal priority again.
    s.rst = 1; s.flush = 1;
    step(s);
    cmp("rst_mid_stall_cnt", 32'(bus.stall_cnt), 32'd0);
    cmp("rst_mid_flush_cnt", 32'(bus.flush_cnt), 32'd0);
    s.rst = 0;
    step(s);

    for (int i = 0; i < 500; i++) step(rand_stim());

    for (int i = 0; i < 5 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/ex_mem_pipe_reg.md
Name: ex_mem_pipe_reg

Overview:
Parametrised EX/MEM pipeline register for the five-stage MIPS core; carries ALU result, store data, PC, write-back destination and MEM/WB control from execute to memory stage. Adds valid tracking, stall (hold), flush (bubble insert), branch-resolution and forwarding outputs, and saturating stall/flush event counters for the hazard unit and debug.

Parameters:
DATA_W, 32, width of aluResult, rt, pc
REG_ADDR_W, 5, width of write-back destination
LOAD_MODE_W, 2, width of load_mode field
CNT_W, 16, width of each event counter

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
stall  in  1  hold current contents
flush  in  1  replace next contents with bubble
valid_in  in  1  EX instruction valid
RegWrite_in, MemWrite_in, MemRead_in, MemToReg_in, branch_in, zero_in  in  1 each  control/flags from EX
load_mode_in  in  LOAD_MODE_W  load size/sign mode
writebackDestination_in  in  REG_ADDR_W  dest register
aluResult_in, rt_in, pc_in  in  DATA_W each  datapath values
valid_out  out  1  MEM-stage instruction valid
RegWrite_out, MemWrite_out, MemRead_out, MemToReg_out, branch_out, zero_out  out  1 each  registered copies
load_mode_out  out  LOAD_MODE_W
writebackDestination_out  out  REG_ADDR_W
aluResult_out, rt_out, pc_out  out  DATA_W each
branch_taken  out  1  valid_out & branch_out & zero_out (combinational from regs)
fwd_en  out  1  valid_out & RegWrite_out & (writebackDestination_out != 0)
stall_cnt  out  CNT_W  cycles with stall=1 & flush=0 since reset
flush_cnt  out  CNT_W  cycles with flush=1 since reset

Behaviour:
- Reset (rst=1 at posedge, overrides everything): all registered outputs 0, valid_out=0, both counters 0.
- Latency: 1 cycle; inputs sampled at posedge appear on outputs after it.
- Priority per posedge: rst > flush > stall > load.
- Load (stall=0, flush=0): every *_out <= *_in, valid_out <= valid_in.
- Stall (stall=1, flush=0): all registers hold, valid_out holds; stall_cnt += 1.
- Flush (flush=1, any stall): valid_out, RegWrite, MemWrite, MemRead, MemToReg, branch, zero <= 0; datapath fields (aluResult, rt, pc, dest, load_mode) <= inputs (don't-care, loaded for determinism); flush_cnt += 1.
- Bubble gating: when valid_in=0 on a load, control bits still register as given, but all side-effecting outputs consumers use (branch_taken, fwd_en) are gated by valid_out; MemWrite_out/RegWrite_out are additionally forced 0 when valid_in=0.
- Counters saturate at 2^CNT_W-1; no wrap.
- Reset asserted mid-stall or mid-flush: reset wins that cycle; next cycle normal priority.
- branch_taken and fwd_en are pure functions of registered state; no input-to-output combinational path.

Decomposition:
- Shared package: DATA_W/REG_ADDR_W/LOAD_MODE_W defaults, load_mode encodings (LM_WORD, LM_HALF, LM_BYTE), REG_ZERO constant.
- One sub-module: sat_counter (parametrised width, synchronous rst, inc enable, saturating); instantiated twice.

Test Plan:
- Reset: rst=1 with all inputs 1/0xFFFFFFFF -> all outputs 0, counters 0 after posedge.
- Load: valid_in=1, RegWrite_in=1, dest=5'd9, aluResult_in=0x1234_5678 -> next cycle same on outputs, fwd_en=1; dest=0 -> fwd_en=0.
- Stall: load A (alu=0x10), then stall=1 for 3 cycles with alu_in=0x20 -> alu_out stays 0x10, stall_cnt=3; release -> 0x20.
- Flush over stall: stall=1, flush=1, MemWrite_in=1 -> valid_out=0, MemWrite_out=0, flush_cnt=1, stall_cnt unchanged.
- Branch: branch_in=1, zero_in=1, valid_in=1 -> branch_taken=1; same with valid_in=0 -> branch_taken=0.
- Saturation: CNT_W=3, stall 10 cycles -> stall_cnt=7 and holds.
